// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pkg
// Shared definitions for the fetch sequencer and its fetch buffer:
//   - default reset PC and populated ROM size
//   - NOP encoding (all-zero word, an sll nop)
//   - fetch-buffer entry layout {instr, pc_plus4}
// No ports (package).
// -----------------------------------------------------------------------------
package fetch_sequencer_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam int unsigned ROM_BYTES_DEF = 60;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
  localparam int unsigned FETCH_ENTRY_W = 64;

  // One buffered fetch: the instruction word and the address after it.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } fetch_entry_t;

  function automatic fetch_entry_t pack_entry(input logic [31:0] instr,
                                              input logic [31:0] pc_plus4);
    fetch_entry_t e;
    e.instr    = instr;
    e.pc_plus4 = pc_plus4;
    return e;
  endfunction

endpackage

// File: rtl/fetch_sequencer_fifo.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_fifo
// Small synchronous FIFO used as the fetch buffer (DEPTH entries of W bits).
// flush empties the FIFO and wins over push/pop in the same cycle.
// A push into a full FIFO together with a pop is legal: the head is read
// combinationally before the edge, so overwriting its slot is safe.
// Ports:
//   clk_i    in   clock, rising edge
//   reset_i  in   synchronous active-high reset (pointers/count only)
//   push_i   in   write din_i at the tail
//   pop_i    in   drop the head entry
//   flush_i  in   discard all entries
//   din_i    in   W-bit entry to write
//   full_o   out  DEPTH entries held
//   empty_o  out  no entries held
//   head_o   out  oldest entry (undefined while empty)
// -----------------------------------------------------------------------------
module fetch_sequencer_fifo
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = FETCH_ENTRY_W
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] din_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + AW'(1);
      if (pop_i)  rd_d = rd_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries data only, so it is never reset.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_q] <= din_i;
  end

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Owns the program counter, reads the combinational instruction ROM at pc and
// queues {instr, pc+4} into a small fetch buffer feeding the IF/ID register.
// Handles decode back-pressure and branch/jump redirects (which flush the
// buffer and restart fetch at the word-aligned target).
//
// Build option: define FETCH_BOUND_EN to stop fetching once pc reaches
// ROM_BYTES (sticky fetch_halted, cleared by reset or redirect). Without it,
// fetch runs on past the ROM and the port fetch_halted does not exist.
//
// Ports:
//   clk             in   clock, rising edge
//   reset           in   synchronous active-high reset
//   imem_addr       out  ROM byte address (= pc)
//   imem_instr      in   ROM word at imem_addr, same cycle
//   redirect_valid  in   taken branch/jump: flush and refetch
//   redirect_pc     in   redirect target (bits [1:0] ignored)
//   id_ready        in   decode takes the head entry this cycle
//   id_valid        out  head entry valid
//   id_instr        out  head instruction
//   id_pc_plus4     out  head entry's pc+4
//   fetch_halted    out  fetch stopped at ROM bound (FETCH_BOUND_EN only)
// -----------------------------------------------------------------------------
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
`ifdef FETCH_BOUND_EN
  parameter int unsigned ROM_BYTES = ROM_BYTES_DEF,
`endif
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4
`ifdef FETCH_BOUND_EN
  ,
  output logic        fetch_halted
`endif
);

  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_plus4;
  logic         enq, deq;
  logic         halted;
  logic         out_of_rom;
  logic         fifo_full, fifo_empty;
  fetch_entry_t push_entry;
  fetch_entry_t head;

  assign pc_plus4  = pc_q + 32'd4;   // wraps modulo 2^32
  assign imem_addr = pc_q;

  // Fetch-bound logic: halted only ever rises in the bounded build.
`ifdef FETCH_BOUND_EN
  logic halted_q, halted_d;

  assign out_of_rom = (pc_q >= 32'(ROM_BYTES));

  always_comb begin
    halted_d = halted_q;
    if (redirect_valid)  halted_d = 1'b0;
    else if (out_of_rom) halted_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) halted_q <= 1'b0;
    else       halted_q <= halted_d;
  end

  assign halted       = halted_q;
  assign fetch_halted = halted_q;
`else
  assign out_of_rom = 1'b0;
  assign halted     = 1'b0;
`endif

  // Redirect blocks both sides so no wrong-path entry moves this cycle.
  // A full buffer may still accept when its head leaves in the same cycle.
  assign deq = !fifo_empty && id_ready && !redirect_valid;
  assign enq = !redirect_valid && !halted && !out_of_rom && (!fifo_full || deq);

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) pc_d = {redirect_pc[31:2], 2'b00};
    else if (enq)       pc_d = pc_plus4;
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  assign push_entry = pack_entry(imem_instr, pc_plus4);

  fetch_sequencer_fifo #(
    .DEPTH (BUF_DEPTH),
    .W     (FETCH_ENTRY_W)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (enq),
    .pop_i   (deq),
    .flush_i (redirect_valid),
    .din_i   (push_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

  // Outputs read straight from the buffer head; forced quiet during reset.
  assign id_valid    = !reset && !fifo_empty;
  assign id_instr    = reset ? NOP_INSTR : head.instr;
  assign id_pc_plus4 = reset ? 32'h0     : head.pc_plus4;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
`ifdef FETCH_BOUND_EN
  logic        fetch_halted;
`endif

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  // ROM model: populated below byte 60, zero (nop) above.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a < 32'd60) return 32'hA510_0000 | (a >> 2) | 32'h0000_0100;
    return 32'h0;
  endfunction

  assign imem_instr = rom_word(imem_addr);

  fetch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc_plus4    (id_pc_plus4)
`ifdef FETCH_BOUND_EN
    ,
    .fetch_halted   (fetch_halted)
`endif
  );

  task automatic push_exp(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      logic [31:0] pc;
      pc = start + 32'(4 * i);
      e.instr = rom_word(pc);
      e.pc4   = pc + 32'd4;
      exp_q.push_back(e);
    end
  endtask

  // Called at a negedge with inputs already set. Pops one expectation per
  // accepted head; strict also demands id_valid every cycle.
  task automatic drain(input string name, input int max_cycles, input bit strict);
    int cyc = 0;
    while (exp_q.size() > 0 && cyc < max_cycles) begin
      if (strict) begin
        checks++;
        if (id_valid !== 1'b1) $display("FAIL %s valid: got %b want 1 (cycle %0d)", name, id_valid, cyc);
        else passed++;
      end
      if (id_valid === 1'b1 && id_ready && !redirect_valid) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (id_pc_plus4 !== e.pc4) $display("FAIL %s pc_plus4: got %h want %h", name, id_pc_plus4, e.pc4);
        else passed++;
        checks++;
        if (id_instr !== e.instr) $display("FAIL %s instr: got %h want %h", name, id_instr, e.instr);
        else passed++;
      end
      cyc++;
      if (exp_q.size() > 0) @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL %s timeout: got %0d entries left want 0", name, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (id_valid !== 1'b0) $display("FAIL reset valid: got %b want 0", id_valid); else passed++;
    checks++; if (id_instr !== 32'h0) $display("FAIL reset instr: got %h want 0", id_instr); else passed++;
    checks++; if (id_pc_plus4 !== 32'h0) $display("FAIL reset pc4: got %h want 0", id_pc_plus4); else passed++;
    checks++; if (imem_addr !== 32'h0) $display("FAIL reset addr: got %h want 0", imem_addr); else passed++;
`ifdef FETCH_BOUND_EN
    checks++; if (fetch_halted !== 1'b0) $display("FAIL reset halted: got %b want 0", fetch_halted); else passed++;
`endif
  endtask

  task automatic test_stream();
    reset = 1'b0; id_ready = 1'b1;
    @(negedge clk);
    push_exp(32'h0, 12);
    drain("stream", 12, 1'b1);
  endtask

  task automatic test_stall();
    reset = 1'b1; id_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (imem_addr !== 32'h8) $display("FAIL stall addr: got %h want 8", imem_addr); else passed++;
    checks++; if (id_valid !== 1'b1) $display("FAIL stall valid: got %b want 1", id_valid); else passed++;
    checks++; if (id_pc_plus4 !== 32'h4) $display("FAIL stall head: got %h want 4", id_pc_plus4); else passed++;
    id_ready = 1'b1;
    push_exp(32'h0, 6);
    drain("stall_release", 6, 1'b1);
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    redirect_valid = 1'b1; redirect_pc = tgt; id_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic test_redirect_full();
    id_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (id_valid !== 1'b1) $display("FAIL redir pre valid: got %b want 1", id_valid); else passed++;
    do_redirect(32'h14);
    checks++; if (id_valid !== 1'b0) $display("FAIL redir leak valid: got %b want 0", id_valid); else passed++;
    checks++; if (imem_addr !== 32'h14) $display("FAIL redir addr: got %h want 14", imem_addr); else passed++;
    @(negedge clk);
    push_exp(32'h14, 4);
    drain("redirect", 4, 1'b1);
  endtask

  task automatic test_redirect_unaligned();
    do_redirect(32'h17);
    checks++; if (imem_addr !== 32'h14) $display("FAIL unaligned addr: got %h want 14", imem_addr); else passed++;
    @(negedge clk);
    push_exp(32'h14, 3);
    drain("unaligned", 3, 1'b1);
  endtask

  task automatic test_bound();
    do_redirect(32'h30);
    @(negedge clk);
`ifdef FETCH_BOUND_EN
    push_exp(32'h30, 3);
    drain("bound", 3, 1'b1);
    repeat (2) @(negedge clk);
    checks++; if (fetch_halted !== 1'b1) $display("FAIL bound halted: got %b want 1", fetch_halted); else passed++;
    checks++; if (id_valid !== 1'b0) $display("FAIL bound valid: got %b want 0", id_valid); else passed++;
    checks++; if (imem_addr !== 32'd60) $display("FAIL bound addr: got %h want 3c", imem_addr); else passed++;
`else
    push_exp(32'h30, 6);
    drain("past_rom", 6, 1'b1);
`endif
  endtask

`ifndef FETCH_BOUND_EN
  task automatic test_wrap();
    do_redirect(32'hFFFF_FFF8);
    @(negedge clk);
    push_exp(32'hFFFF_FFF8, 4);
    drain("wrap", 4, 1'b1);
  endtask
`endif

  task automatic test_reset_mid();
    redirect_valid = 1'b1; redirect_pc = 32'h0; id_ready = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (id_valid !== 1'b1) $display("FAIL rstmid pre valid: got %b want 1", id_valid); else passed++;
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h20;
    @(negedge clk);
    checks++; if (id_valid !== 1'b0) $display("FAIL rstmid valid: got %b want 0", id_valid); else passed++;
    checks++; if (imem_addr !== 32'h0) $display("FAIL rstmid addr: got %h want 0", imem_addr); else passed++;
    redirect_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0; id_ready = 1'b1;
    @(negedge clk);
`ifdef FETCH_BOUND_EN
    checks++; if (fetch_halted !== 1'b0) $display("FAIL rstmid halted: got %b want 0", fetch_halted); else passed++;
`endif
    push_exp(32'h0, 4);
    drain("after_reset", 4, 1'b1);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_redirect_unaligned();
    test_bound();
`ifndef FETCH_BOUND_EN
    test_wrap();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
